// File: rtl/hdc_inference_scoreboard_if.sv
// Inference-check and readout signals between an HDC classifier/host and the scoreboard.
// Slave is the scoreboard; master is the classifier/host driving checks and read requests.
interface hdc_inference_scoreboard_if #(
  parameter int CLASS_BITS  = 5,
  parameter int COUNT_WIDTH = 11
);
  logic                   check_valid;
  logic [CLASS_BITS-1:0]  class_inference;
  logic [CLASS_BITS-1:0]  correct_class;
  logic                   rd_req;
  logic [CLASS_BITS-1:0]  rd_class;
  logic                   rd_valid;
  logic [COUNT_WIDTH-1:0] rd_hits;
  logic [COUNT_WIDTH-1:0] rd_total;
  logic [COUNT_WIDTH-1:0] rd_false_pos;

  modport slave (
    input  check_valid, class_inference, correct_class, rd_req, rd_class,
    output rd_valid, rd_hits, rd_total, rd_false_pos
  );

  modport master (
    output check_valid, class_inference, correct_class, rd_req, rd_class,
    input  rd_valid, rd_hits, rd_total, rd_false_pos
  );
endinterface

// File: rtl/hdc_inference_scoreboard.sv
// Accuracy scoreboard for the HDC classifier: saturating global and per-class
// hit/total/false-positive tallies with a registered per-class readout port.
module hdc_inference_scoreboard #(
  parameter int CLASS_COUNT = 26,
  parameter int CLASS_BITS  = 5,
  parameter int COUNT_WIDTH = 11
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   clear,
  input  logic                   arm,
  input  logic                   finish,
  hdc_inference_scoreboard_if.slave bus,
  output logic                   armed,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] total_queries,
  output logic [COUNT_WIDTH-1:0] total_correct,
  output logic [COUNT_WIDTH-1:0] invalid_labels
);

  localparam logic [CLASS_BITS:0] CC_L = (CLASS_BITS+1)'(CLASS_COUNT);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_DONE} state_t;

  state_t state_q, state_d;
  logic   armed_q, done_q;
  logic   accept;
  logic   l_ok, p_ok, rd_ok;

  logic [COUNT_WIDTH-1:0] tq_q, tc_q, inv_q;
  logic [COUNT_WIDTH-1:0] hits_q [CLASS_COUNT];
  logic [COUNT_WIDTH-1:0] tot_q  [CLASS_COUNT];
  logic [COUNT_WIDTH-1:0] fp_q   [CLASS_COUNT];

  logic                   rd_valid_q;
  logic [COUNT_WIDTH-1:0] rd_hits_q, rd_total_q, rd_fp_q;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign l_ok  = {1'b0, bus.correct_class}   < CC_L;
  assign p_ok  = {1'b0, bus.class_inference} < CC_L;
  assign rd_ok = {1'b0, bus.rd_class}        < CC_L;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    if (clear) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (arm)    state_d = S_ARMED;
        S_ARMED: if (finish) state_d = S_DONE;
        default: state_d = state_q;
      endcase
      accept = en && bus.check_valid && (state_q == S_ARMED);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      armed_q <= 1'b0;
      done_q  <= 1'b0;
    end else if (en) begin
      state_q <= state_d;
      armed_q <= (state_d == S_ARMED);
      done_q  <= (state_d == S_DONE);
    end
  end

  // Out-of-range labels only bump the invalid tally; per-class arrays are indexed only when guarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tq_q  <= '0;
      tc_q  <= '0;
      inv_q <= '0;
      for (int i = 0; i < CLASS_COUNT; i++) begin
        hits_q[i] <= '0;
        tot_q[i]  <= '0;
        fp_q[i]   <= '0;
      end
    end else if (en) begin
      if (clear) begin
        tq_q  <= '0;
        tc_q  <= '0;
        inv_q <= '0;
        for (int i = 0; i < CLASS_COUNT; i++) begin
          hits_q[i] <= '0;
          tot_q[i]  <= '0;
          fp_q[i]   <= '0;
        end
      end else if (accept) begin
        tq_q <= sat_inc(tq_q);
        if (!l_ok) begin
          inv_q <= sat_inc(inv_q);
        end else begin
          tot_q[bus.correct_class] <= sat_inc(tot_q[bus.correct_class]);
          if (bus.class_inference == bus.correct_class) begin
            hits_q[bus.correct_class] <= sat_inc(hits_q[bus.correct_class]);
            tc_q <= sat_inc(tc_q);
          end else if (p_ok) begin
            fp_q[bus.class_inference] <= sat_inc(fp_q[bus.class_inference]);
          end
        end
      end
    end
  end

  // Readout samples the arrays before this edge's update, so a same-cycle read sees old values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_hits_q  <= '0;
      rd_total_q <= '0;
      rd_fp_q    <= '0;
    end else if (en) begin
      rd_valid_q <= bus.rd_req;
      if (bus.rd_req) begin
        if (rd_ok) begin
          rd_hits_q  <= hits_q[bus.rd_class];
          rd_total_q <= tot_q[bus.rd_class];
          rd_fp_q    <= fp_q[bus.rd_class];
        end else begin
          rd_hits_q  <= '0;
          rd_total_q <= '0;
          rd_fp_q    <= '0;
        end
      end
    end else begin
      rd_valid_q <= 1'b0;
    end
  end

  assign armed            = armed_q;
  assign done             = done_q;
  assign total_queries    = tq_q;
  assign total_correct    = tc_q;
  assign invalid_labels   = inv_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.rd_hits      = rd_hits_q;
  assign bus.rd_total     = rd_total_q;
  assign bus.rd_false_pos = rd_fp_q;

endmodule
